// File: rtl/ysyx_22050550_csr_pkg.sv
// Shared CSR constants for the machine-mode CSR file and its interrupt FSM.
package ysyx_22050550_csr_pkg;

  // CSR addresses
  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] CSRMIE  = 12'h304;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] CSRMIP  = 12'h344;

  // wbcsren bit positions
  localparam int WB_MEPC    = 0;
  localparam int WB_MCAUSE  = 1;
  localparam int WB_MTVEC   = 2;
  localparam int WB_MSTATUS = 3;
  localparam int WB_MIE     = 4;
  localparam int WB_MIP     = 5;

  // Interesting bit positions inside the CSRs
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIP_MTIP     = 7;

  // Reset values
  localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800;
  localparam logic [63:0] CSR_ZERO    = 64'h0;

  // Machine timer interrupt cause (interrupt bit + code 7)
  localparam logic [63:0] INTR_CAUSE_MTI = 64'h8000_0000_0000_0007;

  typedef enum logic [1:0] {
    INTR_IDLE  = 2'd0,
    INTR_PEND  = 2'd1,
    INTR_TAKEN = 2'd2
  } intr_state_e;

endpackage

// File: rtl/ysyx_22050550_intr_fsm.sv
// Machine timer interrupt sequencer: raises a request while enabled and
// pending, hands a one-cycle trap strobe to the CSR file on ack, then waits
// for mret (MIE back to 1) before it can fire again.
module ysyx_22050550_intr_fsm
  import ysyx_22050550_csr_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        mstatus_mie_i,
  input  logic        mie_mtie_i,
  input  logic        mip_mtip_i,
  input  logic        intr_ack_i,
  output logic        intr_req_o,
  output logic [63:0] intr_cause_o,
  output logic        trap_o
);

  intr_state_e state_q, state_d;
  logic        intr_en;

  assign intr_en = mstatus_mie_i & mie_mtie_i & mip_mtip_i;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= INTR_IDLE;
    else       state_q <= state_d;
  end

  // Next state and outputs; an ack accepted in PEND wins over a same-cycle
  // enable drop because the front end has already committed to the trap.
  always_comb begin
    state_d      = state_q;
    intr_req_o   = 1'b0;
    intr_cause_o = CSR_ZERO;
    trap_o       = 1'b0;
    case (state_q)
      INTR_IDLE: begin
        if (intr_en) state_d = INTR_PEND;
      end
      INTR_PEND: begin
        intr_req_o   = 1'b1;
        intr_cause_o = INTR_CAUSE_MTI;
        if (intr_ack_i) begin
          trap_o  = 1'b1;
          state_d = INTR_TAKEN;
        end else if (!intr_en) begin
          state_d = INTR_IDLE;
        end
      end
      INTR_TAKEN: begin
        if (mstatus_mie_i) state_d = INTR_IDLE;
      end
      default: state_d = INTR_IDLE;
    endcase
  end

endmodule

// File: rtl/ysyx_22050550_csr_file.sv
// Machine-mode CSR file: WB-committed CSR writes, MTIP mirror, free-running
// mcycle and the trap entry side effects driven by the interrupt FSM.
module ysyx_22050550_csr_file
  import ysyx_22050550_csr_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        io_wb_valid,
  input  logic [7:0]  wbcsren,
  input  logic [63:0] wbmepc,
  input  logic [63:0] wbmcause,
  input  logic [63:0] wbmtvec,
  input  logic [63:0] wbmstatus,
  input  logic [63:0] wbmie,
  input  logic [63:0] wbmip,
  input  logic        mtip,
  input  logic [63:0] io_intr_epc,
  input  logic        io_intr_ack,
  output logic [63:0] mepc,
  output logic [63:0] mcause,
  output logic [63:0] mtvec,
  output logic [63:0] mstatus,
  output logic [63:0] mie,
  output logic [63:0] mip,
  output logic [63:0] mcycle,
  output logic        io_intr_req,
  output logic [63:0] io_intr_cause
);

  logic [63:0] mepc_q, mcause_q, mtvec_q, mstatus_q, mie_q, mip_q, mcycle_q;
  logic [63:0] mcycle_d, trap_mstatus_d;
  logic [5:0]  wr;
  logic        trap;
  logic        unused_bits;

  // Enables only count on a committed WB slot; bits 7:6 carry nothing.
  assign wr          = wbcsren[5:0] & {6{io_wb_valid}};
  assign unused_bits = ^{wbcsren[7:6], wbmip[MIP_MTIP]};
  assign mcycle_d    = mcycle_q + 64'd1;

  ysyx_22050550_intr_fsm u_intr_fsm (
    .clock        (clock),
    .reset        (reset),
    .mstatus_mie_i(mstatus_q[MSTATUS_MIE]),
    .mie_mtie_i   (mie_q[MIE_MTIE]),
    .mip_mtip_i   (mip_q[MIP_MTIP]),
    .intr_ack_i   (io_intr_ack),
    .intr_req_o   (io_intr_req),
    .intr_cause_o (io_intr_cause),
    .trap_o       (trap)
  );

  // Trap entry stacks MIE into MPIE and masks further interrupts.
  always_comb begin
    trap_mstatus_d               = mstatus_q;
    trap_mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
    trap_mstatus_d[MSTATUS_MIE]  = 1'b0;
  end

  // CSR registers: reset first, then trap entry overrides WB on the
  // trap-owned CSRs; the others take WB writes regardless of the trap.
  always_ff @(posedge clock) begin
    if (reset) begin
      mepc_q    <= CSR_ZERO;
      mcause_q  <= CSR_ZERO;
      mtvec_q   <= CSR_ZERO;
      mstatus_q <= MSTATUS_RST;
      mie_q     <= CSR_ZERO;
      mip_q     <= CSR_ZERO;
      mcycle_q  <= CSR_ZERO;
    end else begin
      mcycle_q <= mcycle_d;
      if (trap) begin
        mepc_q    <= io_intr_epc;
        mcause_q  <= io_intr_cause;
        mstatus_q <= trap_mstatus_d;
      end else begin
        if (wr[WB_MEPC])    mepc_q    <= wbmepc;
        if (wr[WB_MCAUSE])  mcause_q  <= wbmcause;
        if (wr[WB_MSTATUS]) mstatus_q <= wbmstatus;
      end
      if (wr[WB_MTVEC]) mtvec_q <= wbmtvec;
      if (wr[WB_MIE])   mie_q   <= wbmie;
      // MTIP is a pure mirror of the CLINT level; WB never owns it.
      if (wr[WB_MIP]) mip_q <= {wbmip[63:MIP_MTIP+1], mtip, wbmip[MIP_MTIP-1:0]};
      else            mip_q[MIP_MTIP] <= mtip;
    end
  end

  assign mepc    = mepc_q;
  assign mcause  = mcause_q;
  assign mtvec   = mtvec_q;
  assign mstatus = mstatus_q;
  assign mie     = mie_q;
  assign mip     = mip_q;
  assign mcycle  = mcycle_q;

endmodule
